ldm_stm_sequencer: RTL
======================

Name: ldm_stm_sequencer

Overview:
- Multi-register transfer sequencer for ARM LDM/STM.
- Walks a 16-bit register list, one register per memory handshake.
- Downstream side drives the register file write port (C address, ENABLE, write data) and read port A.
- Upstream side receives MEM_RDATA for loads and forwards PA to memory for stores.
- Sits between the decode/control unit and the 16x32 register file.

Parameters:
- WORD_BYTES, 4, address step per transferred register.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  one-cycle request; sampled only in IDLE.
- IS_LOAD  input  1  1 = LDM (memory to RF), 0 = STM (RF to memory).
- UP  input  1  1 = increment-after, 0 = decrement-before.
- REG_LIST  input  16  bit i set = transfer Ri.
- BASE_ADDR  input  32  base address from Rn.
- BASE_REG  input  4  Rn index, used only with writeback.
- MEM_READY  input  1  memory accepts/returns the current word.
- MEM_RDATA  input  32  load data, valid with MEM_READY.
- RF_PA  input  32  register file port A read data (combinational).
- RF_A  output  4  register file read select.
- RF_C  output  4  register file write select.
- RF_WE  output  1  register file write enable (drives decoder ENABLE).
- RF_WDATA  output  32  register file write data.
- MEM_REQ  output  1  transfer request.
- MEM_WE  output  1  1 = store.
- MEM_ADDR  output  32  word address.
- MEM_WDATA  output  32  store data (= RF_PA).
- BUSY  output  1  high outside IDLE.
- DONE  output  1  one-cycle completion pulse.
- FINAL_ADDR  output  32  updated base address.

Behaviour:
- Reset: state IDLE; every output 0.
  - Reset mid-transfer aborts immediately: no further RF_WE or MEM_REQ.
- States: IDLE, XFER, WB, DONE.
- IDLE:
  - On START, latch REG_LIST, IS_LOAD, BASE_REG.
  - N = popcount(REG_LIST).
  - FINAL_ADDR = BASE_ADDR + 4N when UP, else BASE_ADDR - 4N; modulo 2^32, wrap permitted.
  - Start address = BASE_ADDR when UP, else BASE_ADDR - 4N.
  - N = 0: go straight to DONE, no transfers, FINAL_ADDR = BASE_ADDR.
  - Otherwise go to XFER.
- XFER:
  - MEM_REQ = 1; MEM_WE = !IS_LOAD.
  - Current register = lowest set bit of the pending list; RF_A = current register.
  - MEM_ADDR is a registered pointer.
  - Registers are always transferred lowest index to lowest address.
  - MEM_READY low: hold all outputs stable.
  - MEM_READY high:
    - Clear the pending bit; add 4 to the pointer.
    - For a load, register MEM_RDATA and the register index. Next cycle: RF_WE = 1, RF_C = index, RF_WDATA = data (one-cycle write latency).
    - Last pending bit: go to WB, else stay in XFER.
  - Back-to-back MEM_READY gives one transfer per cycle.
- WB: MEM_REQ = 0; completes the final load write (RF_WE for stores = 0). Then go to DONE.
- DONE: DONE = 1 for one cycle, BUSY = 1. Then go to IDLE.
- START while BUSY is ignored.
- RF_WE never asserts in IDLE.
- MEM_WDATA = RF_PA combinationally during XFER, else 0.

Optional Feature:
- Macro: LDM_STM_WRITEBACK_EN.
- Defined:
  - In DONE, RF_WE = 1, RF_C = BASE_REG, RF_WDATA = FINAL_ADDR.
  - Suppressed when IS_LOAD and REG_LIST[BASE_REG] = 1 (loaded value wins).
- Undefined: DONE never writes; BASE_REG is ignored.

Test Plan:
- STM, UP = 1, BASE = 0x100, REG_LIST = 0x0005, R0 = 0xA, R2 = 0xB, MEM_READY tied 1 -> writes 0xA@0x100 then 0xB@0x104; DONE 4 cycles after START; FINAL_ADDR = 0x108.
- LDM, UP = 0, BASE = 0x200, REG_LIST = 0x8003, MEM_RDATA 1, 2, 3 -> addresses 0x1F4, 0x1F8, 0x1FC; R0 = 1, R1 = 2, R15 = 3; FINAL_ADDR = 0x1F4.
- LDM with MEM_READY low 3 cycles per word -> MEM_ADDR/RF_A held; RF_WE exactly once per word.
- REG_LIST = 0 -> DONE the cycle after START; no MEM_REQ; FINAL_ADDR = BASE_ADDR.
- RESET asserted during second of four transfers -> next cycle all outputs 0, BUSY = 0, no further RF_WE.
- With LDM_STM_WRITEBACK_EN: LDM BASE_REG = 3, REG_LIST = 0x0003, BASE = 0xFFFFFFFC, UP -> R3 = 0x00000004 (wrap). Repeat with REG_LIST = 0x0008 -> R3 = loaded data.

Source files
------------

// File: rtl/ldm_stm_sequencer.sv
// ---------------------------------------------------------------------------
// ldm_stm_sequencer
//
// Multi-register transfer sequencer for ARM LDM/STM. It walks a 16-bit
// register list and moves one register per memory handshake. The lowest
// register index always goes to the lowest address. Loads write the
// register file one cycle after the memory handshake.
//
// Optional feature (compile-time macro LDM_STM_WRITEBACK_EN):
//   When defined, the DONE cycle writes FINAL_ADDR back to BASE_REG.
//   This write is skipped when a load also transfers BASE_REG, so the
//   loaded value is kept. When undefined, DONE never writes and BASE_REG
//   has no effect.
//
// Ports:
//   CLK, RESET          clock (rising edge), synchronous active-high reset
//   START               one-cycle request, sampled only in IDLE
//   IS_LOAD, UP         1 = LDM / 0 = STM; 1 = increment-after / 0 = decrement-before
//   REG_LIST            bit i set = transfer Ri
//   BASE_ADDR, BASE_REG base address (Rn value) and Rn index
//   MEM_READY/MEM_RDATA memory handshake and load data
//   RF_PA               register file port A read data (combinational)
//   RF_A                register file read select
//   RF_C, RF_WE, RF_WDATA register file write port
//   MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA  memory request side
//   BUSY, DONE          high outside IDLE / one-cycle completion pulse
//   FINAL_ADDR          updated base address
// ---------------------------------------------------------------------------
module ldm_stm_sequencer #(
    parameter int WORD_BYTES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        IS_LOAD,
    input  logic        UP,
    input  logic [15:0] REG_LIST,
    input  logic [31:0] BASE_ADDR,
    input  logic [3:0]  BASE_REG,
    input  logic        MEM_READY,
    input  logic [31:0] MEM_RDATA,
    input  logic [31:0] RF_PA,
    output logic [3:0]  RF_A,
    output logic [3:0]  RF_C,
    output logic        RF_WE,
    output logic [31:0] RF_WDATA,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] FINAL_ADDR
);

`ifdef LDM_STM_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB, S_DONE} state_t;

    state_t      state;
    logic [15:0] pending;
    logic        is_load_q;
    logic [3:0]  base_reg_q;
    logic        wb_ok;

    logic [4:0]  start_cnt;
    logic [31:0] span;
    logic [31:0] start_addr;
    logic [31:0] final_addr_c;
    logic [15:0] pending_nxt;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
        return c;
    endfunction

    // Index of the lowest set bit. An empty list returns 0.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
        return idx;
    endfunction

    // Decrement-before starts at the bottom of the block. Registers then
    // fill upward, so the lowest index always lands at the lowest address.
    always_comb begin
        start_cnt    = popcount16(REG_LIST);
        span         = 32'(start_cnt) * 32'(WORD_BYTES);
        final_addr_c = UP ? (BASE_ADDR + span) : (BASE_ADDR - span);
        start_addr   = UP ? BASE_ADDR : (BASE_ADDR - span);
        pending_nxt  = pending & (pending - 16'd1);
    end

    // Store data comes straight from read port A. RF_A is already steering
    // that port to the current register.
    assign MEM_WDATA = (state == S_XFER) ? RF_PA : 32'h0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_IDLE;
            pending    <= '0;
            is_load_q  <= 1'b0;
            base_reg_q <= '0;
            wb_ok      <= 1'b0;
            RF_A       <= '0;
            RF_C       <= '0;
            RF_WE      <= 1'b0;
            RF_WDATA   <= '0;
            MEM_REQ    <= 1'b0;
            MEM_WE     <= 1'b0;
            MEM_ADDR   <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            FINAL_ADDR <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    RF_WE <= 1'b0;
                    DONE  <= 1'b0;
                    if (START) begin
                        pending    <= REG_LIST;
                        is_load_q  <= IS_LOAD;
                        base_reg_q <= BASE_REG;
                        wb_ok      <= !(IS_LOAD && REG_LIST[BASE_REG]);
                        FINAL_ADDR <= final_addr_c;
                        MEM_ADDR   <= start_addr;
                        BUSY       <= 1'b1;
                        if (REG_LIST == 16'h0) begin
                            // Empty list: no transfers. The base is written back unchanged.
                            state <= S_DONE;
                            DONE  <= 1'b1;
                            RF_WE <= WB_EN;
                            if (WB_EN) begin
                                RF_C     <= BASE_REG;
                                RF_WDATA <= BASE_ADDR;
                            end
                        end else begin
                            state   <= S_XFER;
                            MEM_REQ <= 1'b1;
                            MEM_WE  <= !IS_LOAD;
                            RF_A    <= lowest_set(REG_LIST);
                        end
                    end
                end

                S_XFER: begin
                    // RF_WE is a single-cycle pulse. During a stall it drops,
                    // so each loaded word is written exactly once.
                    RF_WE <= 1'b0;
                    if (MEM_READY) begin
                        pending  <= pending_nxt;
                        MEM_ADDR <= MEM_ADDR + 32'(WORD_BYTES);
                        if (is_load_q) begin
                            RF_WE    <= 1'b1;
                            RF_C     <= RF_A;
                            RF_WDATA <= MEM_RDATA;
                        end
                        if (pending_nxt == 16'h0) begin
                            state   <= S_WB;
                            MEM_REQ <= 1'b0;
                            MEM_WE  <= 1'b0;
                            RF_A    <= '0;
                        end else begin
                            RF_A <= lowest_set(pending_nxt);
                        end
                    end
                end

                // The final load write is issued during this cycle by the
                // registers set on the last handshake.
                S_WB: begin
                    state <= S_DONE;
                    DONE  <= 1'b1;
                    RF_WE <= WB_EN && wb_ok;
                    if (WB_EN && wb_ok) begin
                        RF_C     <= base_reg_q;
                        RF_WDATA <= FINAL_ADDR;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    RF_WE <= 1'b0;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
